// File: rtl/route_update_sorter_if.sv
// route_update_sorter_if: valid/ready bundle around the route update sorter
// Input side : in_valid, in_ready, in_data (P lanes of W bits), in_upd (per-lane candidate flag)
// Output side: out_valid, out_ready, out_data (sorted lanes), out_upd (surviving flags), out_count
// master is the surrounding datapath, slave is the sorter.
interface route_update_sorter_if #(
    parameter int P  = 4,
    parameter int WD = 7,
    parameter int WE = 4,
    parameter int WI = 5
);
    localparam int W  = WE + 2*WI + WD;
    localparam int CW = $clog2(P) + 1;
    logic            in_valid;
    logic            in_ready;
    logic [P*W-1:0]  in_data;
    logic [P-1:0]    in_upd;
    logic            out_valid;
    logic            out_ready;
    logic [P*W-1:0]  out_data;
    logic [P-1:0]    out_upd;
    logic [CW-1:0]   out_count;
    modport master (
        output in_valid, in_data, in_upd, out_ready,
        input  in_ready, out_valid, out_data, out_upd, out_count
    );
    modport slave (
        input  in_valid, in_data, in_upd, out_ready,
        output in_ready, out_valid, out_data, out_upd, out_count
    );
endinterface

// File: rtl/route_update_sorter.sv
// route_update_sorter: pipelined Batcher sort of P relaxation words by (dest j, cost), keeping the cheapest per dest
// clk    : rising-edge clock
// rst    : synchronous active-high reset, clears all valid bits and the output registers
// bus_io : slave side of route_update_sorter_if (in_* accepted when in_valid & in_ready, out_* held until out_ready)
module route_update_sorter #(
    parameter int P  = 4,
    parameter int WD = 7,
    parameter int WE = 4,
    parameter int WI = 5
) (
    input logic clk,
    input logic rst,
    route_update_sorter_if.slave bus_io
);
    localparam int W  = WE + 2*WI + WD;
    localparam int WM = (WE > WD ? WE : WD) + 1;
    localparam int LG = $clog2(P);
    localparam int S  = LG*(LG+1)/2;
    localparam int KW = 1 + WI + WM + LG;
    localparam int EW = KW + W;
    localparam int CW = LG + 1;

    logic                        en;
    logic [P-1:0][EW-1:0]        in_e;
    logic [S-1:0][P-1:0][EW-1:0] st_q, st_d;
    logic [S:0][P-1:0][EW-1:0]   stg;
    logic [S-1:0]                v_q;
    logic                        out_valid_q;
    logic [P*W-1:0]              out_data_q, out_data_d;
    logic [P-1:0]                out_upd_q, out_upd_d;
    logic [CW-1:0]               out_count_q, out_count_d;

    assign en              = ~out_valid_q | bus_io.out_ready;
    assign bus_io.in_ready = en;

    // Each lane element is {key, word}; key = {~upd, j, cost, lane} so every key is unique
    // and invalid lanes sort above all valid ones.
    for (genvar l = 0; l < P; l++) begin : g_key
        logic [W-1:0] w;
        assign w       = bus_io.in_data[l*W +: W];
        assign in_e[l] = {~bus_io.in_upd[l], w[WD+WI-1:WD], WM'(w[W-1 -: WE]) + WM'(w[WD-1:0]), LG'(l), w};
    end

    // stg[s] feeds comparator stage s; stg[S] is the fully sorted vector.
    assign stg = {st_q, in_e};

    // Batcher odd-even merge sort: one (p,k) pass per registered stage. Comparators inside
    // a pass touch disjoint lanes, so swapping in place is order-independent.
    always_comb begin
        int s;
        logic [P-1:0][EW-1:0] t;
        logic [EW-1:0] x;
        st_d = '0;
        t    = '0;
        x    = '0;
        s    = 0;
        for (int p = 1; p < P; p = p * 2) begin
            for (int k = p; k >= 1; k = k / 2) begin
                t = stg[s];
                for (int j = k % p; j + k < P; j = j + 2 * k) begin
                    for (int i = 0; i < k; i++) begin
                        if (i + j + k < P && (i + j) / (2 * p) == (i + j + k) / (2 * p) &&
                            t[i+j+k][EW-1 -: KW] < t[i+j][EW-1 -: KW]) begin
                            x        = t[i+j];
                            t[i+j]   = t[i+j+k];
                            t[i+j+k] = x;
                        end
                    end
                end
                st_d[s] = t;
                s++;
            end
        end
    end

    // Dedup: a lane loses its flag when the lane just below it is a live update for the same j;
    // that lower lane is the cheaper one because cost follows j in the key.
    always_comb begin
        out_data_d   = '0;
        out_upd_d    = '0;
        out_upd_d[0] = ~stg[S][0][EW-1];
        for (int l = 0; l < P; l++) out_data_d[l*W +: W] = stg[S][l][W-1:0];
        for (int l = 1; l < P; l++) begin
            out_upd_d[l] = ~stg[S][l][EW-1] &
                           ~(~stg[S][l-1][EW-1] & (stg[S][l][WD+WI-1:WD] == stg[S][l-1][WD+WI-1:WD]));
        end
        out_count_d = CW'($countones(out_upd_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_upd_q   <= '0;
            out_count_q <= '0;
        end else if (en) begin
            v_q         <= S'({v_q, bus_io.in_valid});
            st_q        <= st_d;
            out_valid_q <= v_q[S-1];
            out_data_q  <= out_data_d;
            out_upd_q   <= out_upd_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_upd   = out_upd_q;
    assign bus_io.out_count = out_count_q;
endmodule

// File: tb/tb_route_update_sorter.sv
// tb_route_update_sorter: directed and randomized checks of route_update_sorter at P=4 and P=8
module tb_route_update_sorter;
    typedef struct {
        logic [167:0] d;
        logic [7:0]   u;
        int           cnt;
        int           nv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   got4 = 0;
    int   got8 = 0;
    exp_t q4[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    route_update_sorter_if #(.P(4)) b4 ();
    route_update_sorter_if #(.P(8)) b8 ();
    route_update_sorter #(.P(4)) u4 (.clk(clk), .rst(rst), .bus_io(b4));
    route_update_sorter #(.P(8)) u8 (.clk(clk), .rst(rst), .bus_io(b8));

    task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] wrd(input int i, input int j, input int wij, input int wi);
        return {4'(wij), 5'(i), 5'(j), 7'(wi)};
    endfunction

    function automatic int jof(input logic [167:0] d, input int l);
        return int'(d[l*21+7 +: 5]);
    endfunction

    function automatic int cof(input logic [167:0] d, input int l);
        return int'(d[l*21+17 +: 4]) + int'(d[l*21 +: 7]);
    endfunction

    function automatic logic [167:0] mask(input int nv);
        logic [167:0] m;
        m = '0;
        for (int k = 0; k < nv; k++) m[k*21 +: 21] = '1;
        return m;
    endfunction

    // Reference: order the live candidates by (j, cost, lane); the first of each j run survives.
    function automatic exp_t model(input int n, input logic [167:0] d, input logic [7:0] u);
        exp_t e;
        int   idx[8];
        bit   used[8];
        int   m;
        int   best;
        e.d = '0; e.u = '0; e.cnt = 0; m = 0;
        for (int l = 0; l < n; l++) used[l] = !u[l];
        for (int k = 0; k < n; k++) begin
            best = -1;
            for (int l = 0; l < n; l++)
                if (!used[l] && (best < 0 || jof(d, l)*65536 + cof(d, l)*16 + l <
                                             jof(d, best)*65536 + cof(d, best)*16 + best)) best = l;
            if (best >= 0) begin
                used[best] = 1'b1;
                idx[m] = best;
                m++;
            end
        end
        for (int k = 0; k < m; k++) begin
            e.d[k*21 +: 21] = d[idx[k]*21 +: 21];
            e.u[k] = (k == 0) || jof(d, idx[k]) != jof(d, idx[k-1]);
            e.cnt += int'(e.u[k]);
        end
        e.nv = m;
        return e;
    endfunction

    task automatic rnd(input int n, output logic [167:0] d, output logic [7:0] u);
        d = '0;
        for (int l = 0; l < n; l++)
            d[l*21 +: 21] = wrd(int'($urandom_range(0, 31)), int'($urandom_range(0, n-1)),
                                int'($urandom_range(0, 15)), int'($urandom_range(0, 127)));
        u = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
    endtask

    task automatic step4(input bit v, input logic [83:0] d, input logic [3:0] u, input bit rdy, output bit acc);
        b4.in_valid = v; b4.in_data = d; b4.in_upd = u; b4.out_ready = rdy;
        @(negedge clk);
        if (!rdy && b4.out_valid) check("hold_in_ready4", 168'(b4.in_ready), 168'(0));
        acc = v && b4.in_ready && !rst;
        if (acc) q4.push_back(model(4, 168'(d), 8'(u)));
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input bit v, input logic [167:0] d, input logic [7:0] u, input bit rdy, output bit acc);
        b8.in_valid = v; b8.in_data = d; b8.in_upd = u; b8.out_ready = rdy;
        @(negedge clk);
        acc = v && b8.in_ready && !rst;
        if (acc) q8.push_back(model(8, d, u));
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [83:0] d, input logic [3:0] u, output int n);
        bit acc;
        step4(1'b1, d, u, 1'b1, acc);
        n = 1;
        while (!b4.out_valid && n < 20) begin
            step4(1'b0, '0, '0, 1'b1, acc);
            n++;
        end
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && b4.out_valid === 1'b1) begin
            if (q4.size() == 0) check("spurious4", 168'(b4.out_valid), 168'(0));
            else begin
                e = q4[0];
                check("upd4", 168'(b4.out_upd), 168'(e.u));
                check("cnt4", 168'(b4.out_count), 168'(e.cnt));
                check("dat4", 168'(b4.out_data) & mask(e.nv), e.d & mask(e.nv));
                if (b4.out_ready) begin
                    q4.delete(0);
                    got4++;
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && b8.out_valid === 1'b1) begin
            if (q8.size() == 0) check("spurious8", 168'(b8.out_valid), 168'(0));
            else begin
                e = q8[0];
                check("upd8", 168'(b8.out_upd), 168'(e.u));
                check("cnt8", 168'(b8.out_count), 168'(e.cnt));
                check("dat8", b8.out_data & mask(e.nv), e.d & mask(e.nv));
                if (b8.out_ready) begin
                    q8.delete(0);
                    got8++;
                end
            end
        end
    end

    initial begin
        logic [20:0]  wa, wb, wc, we;
        logic [167:0] d8;
        logic [7:0]   u8;
        bit           acc, rdy;
        int           n, held, base, guard, sent;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_upd = '0; b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.in_upd = '0; b8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid4", 168'(b4.out_valid), 168'(0));
        check("rst_count4", 168'(b4.out_count), 168'(0));
        check("rst_upd4", 168'(b4.out_upd), 168'(0));
        check("rst_data4", 168'(b4.out_data), 168'(0));
        check("rst_ready4", 168'(b4.in_ready), 168'(1));
        check("rst_valid8", 168'(b8.out_valid), 168'(0));
        check("rst_ready8", 168'(b8.in_ready), 168'(1));

        wa = wrd(3, 5, 2, 9); wb = wrd(4, 2, 7, 30); wc = wrd(1, 7, 1, 5); we = wrd(9, 1, 0, 60);
        run4({we, wc, wb, wa}, 4'b1111, n);
        check("distinct_lat", 168'(n), 168'(4));
        check("distinct_data", 168'(b4.out_data), 168'({wc, wa, wb, we}));
        check("distinct_upd", 168'(b4.out_upd), 168'(4'b1111));
        check("distinct_cnt", 168'(b4.out_count), 168'(4));
        step4(1'b0, '0, '0, 1'b1, acc);

        wa = wrd(1, 3, 2, 10); wb = wrd(2, 3, 1, 20); wc = wrd(3, 9, 5, 5); we = wrd(4, 4, 6, 6);
        run4({we, wc, wb, wa}, 4'b1111, n);
        check("dup_data", 168'(b4.out_data), 168'({wc, we, wb, wa}));
        check("dup_upd", 168'(b4.out_upd), 168'(4'b1101));
        check("dup_cnt", 168'(b4.out_count), 168'(3));
        step4(1'b0, '0, '0, 1'b1, acc);

        wa = wrd(1, 8, 15, 127); wb = wrd(2, 8, 0, 100); wc = wrd(5, 1, 1, 1); we = wrd(6, 0, 0, 0);
        run4({we, wc, wb, wa}, 4'b0011, n);
        check("trunc_data", 168'(b4.out_data[41:0]), 168'({wa, wb}));
        check("trunc_upd", 168'(b4.out_upd), 168'(4'b0001));
        check("trunc_cnt", 168'(b4.out_count), 168'(1));
        step4(1'b0, '0, '0, 1'b1, acc);

        wa = wrd(1, 6, 3, 10); wb = wrd(2, 2, 0, 0); wc = wrd(3, 6, 5, 8); we = wrd(4, 1, 0, 0);
        run4({we, wc, wb, wa}, 4'b0101, n);
        check("tie_data", 168'(b4.out_data[41:0]), 168'({wc, wa}));
        check("tie_upd", 168'(b4.out_upd), 168'(4'b0001));
        check("tie_cnt", 168'(b4.out_count), 168'(1));
        step4(1'b0, '0, '0, 1'b1, acc);

        n = 0; held = 0; guard = 0; base = got4;
        while ((n < 6 || q4.size() > 0) && guard < 200) begin
            rdy = 1'b1;
            if (b4.out_valid && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            rnd(4, d8, u8);
            step4(n < 6, d8[83:0], u8[3:0], rdy, acc);
            if (acc) n++;
            guard++;
        end
        check("bp_held", 168'(held), 168'(3));
        check("bp_count", 168'(got4 - base), 168'(6));
        check("bp_drain", 168'(q4.size()), 168'(0));

        rnd(8, d8, u8);
        step8(1'b1, d8, u8, 1'b1, acc);
        n = 1;
        while (!b8.out_valid && n < 20) begin
            step8(1'b0, '0, '0, 1'b1, acc);
            n++;
        end
        check("lat8", 168'(n), 168'(7));
        step8(1'b0, '0, '0, 1'b1, acc);

        for (int k = 0; k < 3; k++) begin
            rnd(8, d8, u8);
            step8(1'b1, d8, u8, 1'b1, acc);
        end
        rst = 1'b1;
        step8(1'b0, '0, '0, 1'b1, acc);
        rst = 1'b0;
        q8.delete();
        check("mid_rst_valid", 168'(b8.out_valid), 168'(0));
        check("mid_rst_count", 168'(b8.out_count), 168'(0));
        check("mid_rst_upd", 168'(b8.out_upd), 168'(0));
        check("mid_rst_ready", 168'(b8.in_ready), 168'(1));
        repeat (12) step8(1'b0, '0, '0, 1'b1, acc);

        sent = 0; guard = 0; base = got8;
        while (sent < 1000 && guard < 20000) begin
            rnd(8, d8, u8);
            step8($urandom_range(0, 3) != 0, d8, u8, $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
            guard++;
        end
        guard = 0;
        while (q8.size() > 0 && guard < 200) begin
            step8(1'b0, '0, '0, 1'b1, acc);
            guard++;
        end
        check("rnd_sent", 168'(sent), 168'(1000));
        check("rnd_count", 168'(got8 - base), 168'(1000));
        check("rnd_drain", 168'(q8.size()), 168'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
